// File: rtl/uart_pkg.sv
// uart_pkg: bus register addresses, TX/RX state encodings and baud divisor for uart_periph
package uart_pkg;
    localparam logic [3:0] ADDR_TX_DATA  = 4'h6;
    localparam logic [3:0] ADDR_RX_DATA  = 4'h2;
    localparam logic [3:0] ADDR_STATUS   = 4'h4;
    localparam logic [3:0] ADDR_LOOPBACK = 4'h8;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
    localparam int CLKS_PER_BIT = clks_per_bit(50_000_000, 115200);
endpackage

// File: rtl/uart_periph_if.sv
// uart_periph_if: J1 CPU I/O bus as seen by the UART peripheral
interface uart_periph_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    modport master(output cs, rd, wr, addr, d_in, input d_out);
    modport slave(input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronized 8N1 receiver holding the last good byte, valid and framing-error flags
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CPB = CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clr,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       done
);
    localparam logic [15:0] LAST = 16'(CPB - 1);
    localparam logic [15:0] HALF = 16'(CPB / 2 - 1);
    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sh, sh_n;
    logic        s1, s2, s3, fall, store, err;
    assign fall = s3 & ~s2;
    always_ff @(posedge clk) begin
        if (!rst) begin
            {s3, s2, s1} <= 3'b111;
            state <= RX_IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            data <= '0;
            valid <= 1'b0;
            frame_err <= 1'b0;
            done <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, rx};
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sh <= sh_n;
            done <= store;
            data <= store ? sh : data;
            valid <= store | (valid & ~clr);
            frame_err <= err | (frame_err & ~clr);
        end
    end
    // a store beats a simultaneous clearing read, so valid survives it
    always_comb begin
        state_n = state;
        cnt_n = cnt + 16'd1;
        idx_n = idx;
        sh_n = sh;
        store = 1'b0;
        err = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START: if (cnt == HALF) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == LAST) begin
                cnt_n = '0;
                sh_n = {s2, sh[7:1]};
                idx_n = idx + 3'd1;
                if (idx == 3'd7) state_n = RX_STOP;
            end
            RX_STOP: if (cnt == LAST) begin
                state_n = RX_IDLE;
                store = s2;
                err = ~s2;
            end
            default: state_n = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART for the J1 I/O bus; UART_LOOPBACK_EN adds a TX->RX loopback register at 0x8
module uart_periph
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD = 115200
) (
    input  logic          clk,
    input  logic          rst,
    uart_periph_if.slave  bus,
    output logic          uart_tx,
    input  logic          uart_rx,
    output logic          done,
    output logic          ledout
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [15:0] LAST = 16'(CPB - 1);
    tx_state_t   tx_state, tx_next;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n, rx_data;
    logic        tx_line_n, wr_q, tx_hit, wr_edge, rd_rx, tx_busy;
    logic        rx_valid, frame_err, rx_in, unused_hi;
    assign tx_hit = bus.cs && bus.wr && bus.addr == ADDR_TX_DATA;
    assign wr_edge = tx_hit && !wr_q;
    assign rd_rx = bus.cs && bus.rd && bus.addr == ADDR_RX_DATA;
    assign tx_busy = tx_state != TX_IDLE;
    assign ledout = tx_busy | rx_valid;
    assign unused_hi = ^bus.d_in[15:8];
`ifdef UART_LOOPBACK_EN
    logic loopback;
    always_ff @(posedge clk) begin
        if (!rst) loopback <= 1'b0;
        else if (bus.cs && bus.wr && bus.addr == ADDR_LOOPBACK) loopback <= bus.d_in[0];
    end
    assign rx_in = loopback ? uart_tx : uart_rx;
`else
    assign rx_in = uart_rx;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            uart_tx <= 1'b1;
            wr_q <= 1'b0;
            bus.d_out <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt <= tx_cnt_n;
            tx_bit <= tx_bit_n;
            tx_sh <= tx_sh_n;
            uart_tx <= tx_line_n;
            wr_q <= tx_hit;
            bus.d_out <= !(bus.cs && bus.rd) ? 16'h0000 :
                         bus.addr == ADDR_RX_DATA ? {8'h00, rx_data} :
                         bus.addr == ADDR_STATUS ? {13'b0, frame_err, rx_valid, tx_busy} : 16'h0000;
        end
    end
    // the line is registered so the pin changes exactly on the state boundary
    always_comb begin
        tx_next = tx_state;
        tx_cnt_n = tx_cnt + 16'd1;
        tx_bit_n = tx_bit;
        tx_sh_n = tx_sh;
        tx_line_n = uart_tx;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (wr_edge) begin
                    tx_next = TX_START;
                    tx_sh_n = bus.d_in[7:0];
                    tx_line_n = 1'b0;
                end
            end
            TX_START: if (tx_cnt == LAST) begin
                tx_next = TX_DATA;
                tx_cnt_n = '0;
                tx_bit_n = '0;
                tx_line_n = tx_sh[0];
            end
            TX_DATA: if (tx_cnt == LAST) begin
                tx_cnt_n = '0;
                tx_bit_n = tx_bit + 3'd1;
                tx_sh_n = tx_sh >> 1;
                tx_line_n = tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
                if (tx_bit == 3'd7) tx_next = TX_STOP;
            end
            TX_STOP: if (tx_cnt == LAST) begin
                tx_next = TX_IDLE;
                tx_cnt_n = '0;
            end
            default: tx_next = TX_IDLE;
        endcase
    end
    uart_rx_core #(.CPB(CPB)) u_rx (
        .clk(clk),
        .rst(rst),
        .rx(rx_in),
        .clr(rd_rx),
        .data(rx_data),
        .valid(rx_valid),
        .frame_err(frame_err),
        .done(done)
    );
endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: randomized self-checking bench for uart_periph against a frame-level UART model
module tb_uart_periph;
    localparam int CPB = 434;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx, done, ledout;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [7:0] m_data;
    logic m_valid, m_ferr;
    logic [15:0] v;
    uart_periph_if bus();
    uart_periph dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx),
        .done(done),
        .ledout(ledout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        if (rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input int hold);
        bus.cs = 1'b1;
        bus.wr = 1'b1;
        bus.addr = a;
        bus.d_in = d;
        repeat (hold) @(negedge clk);
        bus.cs = 1'b0;
        bus.wr = 1'b0;
    endtask
    task automatic bus_read(input logic [3:0] a, output logic [15:0] r);
        bus.cs = 1'b1;
        bus.rd = 1'b1;
        bus.addr = a;
        @(negedge clk);
        r = bus.d_out;
        bus.cs = 1'b0;
        bus.rd = 1'b0;
    endtask
    task automatic check_regs(input string tag);
        logic [15:0] r;
        bus_read(4'h4, r);
        check({tag, "_status"}, r, {13'b0, m_ferr, m_valid, 1'b0});
        bus_read(4'h2, r);
        check({tag, "_data"}, r, {8'h00, m_data});
        m_valid = 1'b0;
        m_ferr = 1'b0;
        bus_read(4'h4, r);
        check({tag, "_cleared"}, r, 16'h0000);
    endtask
    task automatic tx_frame(input logic [7:0] b, input int hold, input bit chk_led);
        logic [9:0] f;
        int mis, lmis;
        f = {1'b1, b, 1'b0};
        mis = 0;
        lmis = 0;
        bus.cs = 1'b1;
        bus.wr = 1'b1;
        bus.addr = 4'h6;
        bus.d_in = {8'h00, b};
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < CPB * 10 + 300; k++) begin
                    if (uart_tx !== (k < CPB * 10 ? f[k / CPB] : 1'b1)) mis++;
                    if (ledout !== (k < CPB * 10)) lmis++;
                    @(negedge clk);
                end
            end
            begin
                repeat (hold - 1) @(negedge clk);
                bus.cs = 1'b0;
                bus.wr = 1'b0;
                if (hold < 100) begin
                    repeat (30) @(negedge clk);
                    bus_write(4'h6, 16'h0000, 1);
                end
            end
        join
        check($sformatf("tx_wave_%02h", b), mis, 0);
        if (chk_led) check("tx_busy", lmis, 0);
    endtask
    task automatic rx_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        int c0, t0;
        f = {stop, b, 1'b0};
        c0 = done_cnt;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check($sformatf("rx_done_cnt_%02h", b), done_cnt - c0, {31'b0, stop});
        if (stop) begin
            check("rx_done_time", done_cyc - t0 > 4000 && done_cyc - t0 < 4250, 1);
            m_data = b;
            m_valid = 1'b1;
        end else m_ferr = 1'b1;
    endtask
    initial begin
        int c0;
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 4'h0;
        bus.d_in = 16'h0000;
        m_data = 8'h00;
        m_valid = 1'b0;
        m_ferr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_dout", bus.d_out, 0);
        check("rst_done", done, 0);
        check("rst_led", ledout, 0);
        rst = 1'b1;
        @(negedge clk);
        bus_read(4'h4, v);
        check("rst_status", v, 0);
        @(negedge clk);
        check("dout_idle", bus.d_out, 0);
        bus_read(4'h5, v);
        check("unmapped_rd", v, 0);
        tx_frame(8'h26, 10, 1);
        tx_frame(8'($urandom), $urandom_range(1, 20), 1);
        tx_frame(8'($urandom), $urandom_range(1, 20), 1);
        tx_frame(8'($urandom), 4400, 1);
`ifndef UART_LOOPBACK_EN
        bus_write(4'h8, 16'h0001, 1);
        bus_read(4'h8, v);
        check("addr8_unmapped", v, 0);
`endif
        rx_frame(8'h75, 1'b1);
        check_regs("rx75");
        rx_frame(8'hC0, 1'b1);
        check_regs("rxc0");
        rx_frame(8'h5A, 1'b0);
        check_regs("rx_ferr");
        c0 = done_cnt;
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB * 11) @(negedge clk);
        check("glitch_done", done_cnt - c0, 0);
        check_regs("glitch");
        for (int i = 0; i < 4; i++) begin
            rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) check_regs("rx_rand");
        end
        check_regs("rx_rand_end");
        fork
            tx_frame(8'($urandom), 5, 0);
            rx_frame(8'($urandom), 1'b1);
        join
        check_regs("duplex");
`ifdef UART_LOOPBACK_EN
        bus_write(4'h8, 16'h0001, 1);
        uart_rx = 1'b0;
        c0 = done_cnt;
        tx_frame(8'h2D, 1, 0);
        check("lb_done", done_cnt - c0, 1);
        m_data = 8'h2D;
        m_valid = 1'b1;
        check_regs("loopback");
        uart_rx = 1'b1;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
